if_fetch_stage: RTL and testbench

//  Instruction-fetch stage directly upstream of the IF/ID pipeline register.

---
 rtl/if_fetch_stage.sv | 191 +++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: fetch PC, in-order req/gnt/rvalid port, fetch queue to IF/ID.
// Optional build macro IF_MISALIGN_CHK_EN adds misalign_o and the misaligned-redirect trap.

module if_fetch_stage_chk #(
  parameter int CNT_W       = 2,
  parameter int QUEUE_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  input logic             rvalid,
  input logic [CNT_W-1:0] outstanding,
  input logic [CNT_W:0]   occupancy
);
  // A response with nothing in flight is a memory-side protocol error.
  no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(rvalid && (outstanding == {CNT_W{1'b0}})));

  occupancy_bounded: assert property (@(posedge clk) disable iff (rst)
    (occupancy <= (CNT_W+1)'(QUEUE_DEPTH)));
endmodule

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] NOP_INSN    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_c_i,
  input  logic        redirect_c_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int               PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W+1)'(QUEUE_DEPTH);

  logic [31:0]      fetch_pc_r;
  logic [31:0]      q_pc_r   [QUEUE_DEPTH];
  logic [31:0]      q_insn_r [QUEUE_DEPTH];
  logic [31:0]      pcf_r    [QUEUE_DEPTH];
  logic [PTR_W-1:0] q_rd_ptr_r, q_wr_ptr_r, pcf_rd_ptr_r, pcf_wr_ptr_r;
  logic [CNT_W-1:0] q_count_r, outstanding_r, discard_r;

  logic             resp_s, drop_s, push_s, pop_s, grant_s, req_s, head_valid_s;
  logic             fetch_hold_s;
  logic [31:0]      redirect_target_s;
  logic [CNT_W:0]   occupancy_s;
  logic [CNT_W-1:0] count_n_s, outstanding_n_s, discard_n_s;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_r;

  assign fetch_hold_s      = misalign_r;
  assign misalign_o        = misalign_r;
  assign redirect_target_s = redirect_pc_i;

  // Misaligned-redirect trap: set by a redirect with nonzero low bits, left by the next redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else if (redirect_c_i) begin
      misalign_r <= (redirect_pc_i[1:0] != 2'b00);
    end else begin
      misalign_r <= misalign_r;
    end
  end
`else
  assign fetch_hold_s      = 1'b0;
  assign redirect_target_s = redirect_pc_i & 32'hFFFF_FFFC;
`endif

  // Handshake qualification, request gating and next values of the occupancy counters.
  always_comb begin
    resp_s          = imem_rvalid_i && (outstanding_r != CNT_ZERO);
    drop_s          = resp_s && (discard_r != CNT_ZERO);
    push_s          = resp_s && (discard_r == CNT_ZERO) && !redirect_c_i && !fetch_hold_s;
    occupancy_s     = {1'b0, q_count_r} + {1'b0, outstanding_r};
    req_s           = !rst && !redirect_c_i && !fetch_hold_s && (occupancy_s < DEPTH_C);
    grant_s         = req_s && imem_gnt_i;
    head_valid_s    = (q_count_r != CNT_ZERO);
    pop_s           = head_valid_s && !stall_c_i && !redirect_c_i;
    count_n_s       = q_count_r;
    outstanding_n_s = outstanding_r;
    discard_n_s     = discard_r;
    if (redirect_c_i) begin
      // Everything still in flight after this cycle's response becomes a discard.
      count_n_s       = CNT_ZERO;
      outstanding_n_s = outstanding_r - CNT_W'(resp_s);
      discard_n_s     = outstanding_r - CNT_W'(resp_s);
    end else begin
      count_n_s       = q_count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      outstanding_n_s = outstanding_r + CNT_W'(grant_s) - CNT_W'(resp_s);
      discard_n_s     = discard_r - CNT_W'(drop_s);
    end
  end

  // Head-of-queue presentation to IF/ID.
  always_comb begin
    imem_req_o    = req_s;
    imem_addr_o   = fetch_pc_r;
    valid_o       = head_valid_s;
    pc_o          = 32'h0000_0000;
    instruction_o = NOP_INSN;
    if (head_valid_s) begin
      pc_o          = q_pc_r[q_rd_ptr_r];
      instruction_o = q_insn_r[q_rd_ptr_r];
    end else if (fetch_hold_s) begin
      pc_o          = fetch_pc_r;
      instruction_o = NOP_INSN;
    end else begin
      pc_o          = 32'h0000_0000;
      instruction_o = NOP_INSN;
    end
  end

  // Fetch PC, counters and queue / PC-FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      q_count_r     <= CNT_ZERO;
      outstanding_r <= CNT_ZERO;
      discard_r     <= CNT_ZERO;
      q_rd_ptr_r    <= PTR_ZERO;
      q_wr_ptr_r    <= PTR_ZERO;
      pcf_rd_ptr_r  <= PTR_ZERO;
      pcf_wr_ptr_r  <= PTR_ZERO;
    end else begin
      q_count_r     <= count_n_s;
      outstanding_r <= outstanding_n_s;
      discard_r     <= discard_n_s;
      if (redirect_c_i) begin
        fetch_pc_r   <= redirect_target_s;
        q_rd_ptr_r   <= PTR_ZERO;
        q_wr_ptr_r   <= PTR_ZERO;
        pcf_rd_ptr_r <= PTR_ZERO;
        pcf_wr_ptr_r <= PTR_ZERO;
      end else begin
        if (grant_s) begin
          fetch_pc_r   <= fetch_pc_r + 32'd4;
          pcf_wr_ptr_r <= pcf_wr_ptr_r + PTR_ONE;
        end
        if (push_s) begin
          q_wr_ptr_r   <= q_wr_ptr_r + PTR_ONE;
          pcf_rd_ptr_r <= pcf_rd_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          q_rd_ptr_r <= q_rd_ptr_r + PTR_ONE;
        end
      end
    end
  end

  // Entry storage; contents are only observed through the counters, so no reset.
  always_ff @(posedge clk) begin
    if (grant_s) begin
      pcf_r[pcf_wr_ptr_r] <= fetch_pc_r;
    end
    if (push_s) begin
      q_pc_r[q_wr_ptr_r]   <= pcf_r[pcf_rd_ptr_r];
      q_insn_r[q_wr_ptr_r] <= imem_rdata_i;
    end
  end

  if_fetch_stage_chk #(
    .CNT_W       (CNT_W),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .rvalid      (imem_rvalid_i),
    .outstanding (outstanding_r),
    .occupancy   (occupancy_s)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: in-order memory model with variable latency,
// directed fetch / stall / redirect / wrap / reset sequences; a monitor checks every output.
`timescale 1ns/1ps
module tb_if_fetch_stage;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_c_i = 1'b0;
  logic        redirect_c_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] instruction_o;
  logic        misal_s;
`ifdef IF_MISALIGN_CHK_EN
  logic        misalign_o;
  assign misal_s = misalign_o;
`else
  assign misal_s = 1'b0;
`endif

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
    .clk(clk), .rst(rst), .stall_c_i(stall_c_i), .redirect_c_i(redirect_c_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .valid_o(valid_o), .pc_o(pc_o), .instruction_o(instruction_o)
`ifdef IF_MISALIGN_CHK_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;

  int          checks = 0;
  int          failures = 0;
  int          delivered = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] exp_q[$];
  pend_t       pend_q[$];

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3C3_0101;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    logic [31:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  task automatic wait_delivered(input string name, input int n, input int budget);
    int target;
    int k;
    target = delivered + n;
    k = 0;
    while (delivered < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (delivered < target) begin
      failures++;
      $display("FAIL %s: delivered %0d required %0d", name, delivered, target);
    end
  endtask

  task automatic wait_valid_pc(input string name, input logic [31:0] exp_pc, input int budget);
    int k;
    k = 0;
    while (!valid_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_bit({name, "_valid"}, valid_o, 1'b1);
    check(name, pc_o, exp_pc);
  endtask

  task automatic do_redirect(input logic [31:0] target, input logic [31:0] exp_start,
                             input int n, input logic with_stall);
    @(negedge clk);
    redirect_c_i  = 1'b1;
    redirect_pc_i = target;
    stall_c_i     = with_stall;
    #3;
    check_bit("redirect_no_req", imem_req_o, 1'b0);
    @(negedge clk);
    redirect_c_i = 1'b0;
    stall_c_i    = 1'b0;
    exp_q.delete();
    push_run(exp_start, n);
    check_bit("flush_valid", valid_o, 1'b0);
  endtask

  // Memory model: grants whenever asked, answers in order after lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        pend_q.delete();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
      end else begin
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = insn_of(pend_q[0].addr);
          void'(pend_q.pop_front());
        end else begin
          imem_rvalid_i = 1'b0;
          imem_rdata_i  = 32'hDEAD_BEEF;
        end
        imem_gnt_i = 1'b1;
        if (imem_req_o) pend_q.push_back('{imem_addr_o, cyc + lat});
      end
    end
  end

  // Monitor: every presented instruction must be the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got pc %h expected no output", pc_o);
        end else begin
          check("out_pc", pc_o, exp_q[0]);
          check("out_insn", instruction_o, insn_of(exp_q[0]));
          if (!stall_c_i && !redirect_c_i) begin
            void'(exp_q.pop_front());
            delivered++;
          end
        end
      end else if (!rst && !misal_s) begin
        check("empty_pc", pc_o, 32'h0);
        check("empty_insn", instruction_o, NOP);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_bit("rst_req", imem_req_o, 1'b0);
    check_bit("rst_valid", valid_o, 1'b0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_insn", instruction_o, NOP);
    exp_q.delete();
    push_run(32'h0, 64);
    rst = 1'b0;
    #3;
    check_bit("first_req", imem_req_o, 1'b1);
    check("first_addr", imem_addr_o, 32'h0);
    @(negedge clk);
    check_bit("valid_cycle1", valid_o, 1'b0);
    @(negedge clk);
    check_bit("valid_cycle2", valid_o, 1'b1);
    check("pc_cycle2", pc_o, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_bit("steady_valid", valid_o, 1'b1);
    end

    // Stall until the queue is full, then hold three cycles
    stall_c_i = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_bit("stall_req", imem_req_o, 1'b0);
      check_bit("stall_valid", valid_o, 1'b1);
      check("stall_pc", pc_o, exp_q[0]);
      @(negedge clk);
    end
    stall_c_i = 1'b0;
    wait_delivered("after_stall", 12, 40);

    // Redirect with two responses in flight
    lat = 3;
    for (int k = 0; k < 50 && pend_q.size() != 2; k++) @(negedge clk);
    check("outstanding_before_redirect", pend_q.size(), 32'd2);
    do_redirect(32'h0000_0100, 32'h0000_0100, 64, 1'b0);
    wait_valid_pc("redirect_pc", 32'h0000_0100, 20);
    wait_delivered("after_redirect", 6, 60);

    // Redirect and stall together
    lat = 1;
    wait_delivered("pre_stall_redirect", 3, 20);
    stall_c_i = 1'b1;
    repeat (2) @(negedge clk);
    do_redirect(32'h0000_0200, 32'h0000_0200, 64, 1'b1);
    wait_valid_pc("stall_redirect_pc", 32'h0000_0200, 20);
    wait_delivered("after_stall_redirect", 6, 40);

    // Back-to-back redirects with responses in flight
    lat = 3;
    repeat (3) @(negedge clk);
    redirect_c_i  = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    @(negedge clk);
    redirect_pc_i = 32'h0000_0340;
    @(negedge clk);
    redirect_c_i = 1'b0;
    exp_q.delete();
    push_run(32'h0000_0340, 64);
    check_bit("b2b_flush_valid", valid_o, 1'b0);
    wait_valid_pc("b2b_pc", 32'h0000_0340, 30);
    wait_delivered("after_b2b", 6, 60);

    // PC wrap past 2^32
    lat = 1;
    do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8, 64, 1'b0);
    wait_valid_pc("wrap_first_pc", 32'hFFFF_FFF8, 20);
    wait_delivered("wrap_stream", 6, 40);

`ifdef IF_MISALIGN_CHK_EN
    do_redirect(32'h0000_0102, 32'h0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_bit("misalign_flag", misalign_o, 1'b1);
      check("misalign_pc", pc_o, 32'h0000_0102);
      check_bit("misalign_req", imem_req_o, 1'b0);
      check_bit("misalign_valid", valid_o, 1'b0);
      @(negedge clk);
    end
    do_redirect(32'h0000_0200, 32'h0000_0200, 64, 1'b0);
    check_bit("misalign_cleared", misalign_o, 1'b0);
    wait_valid_pc("after_misalign_pc", 32'h0000_0200, 20);
`else
    do_redirect(32'h0000_0106, 32'h0000_0104, 64, 1'b0);
    wait_valid_pc("low_bits_forced_pc", 32'h0000_0104, 20);
`endif
    wait_delivered("after_low_bits", 4, 40);

    // Reset mid-transfer drops everything in flight
    lat = 3;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("midrst_req", imem_req_o, 1'b0);
    check_bit("midrst_valid", valid_o, 1'b0);
    check("midrst_insn", instruction_o, NOP);
    exp_q.delete();
    push_run(32'h0, 64);
    rst = 1'b0;
    wait_valid_pc("after_reset_pc", 32'h0, 20);
    wait_delivered("after_reset", 6, 60);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
